// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

    // One iteration per operand bit of the 32-bit datapath.
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Signed ops need operand magnitudes and a sign fix at the end.
    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Two's-complement magnitude, applied only when en is set.
    function automatic logic [31:0] cond_abs(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional negation of the raw {hi, lo} result pair.
// Multiply: the whole 64-bit product is negated as one value.
// Divide: quotient (lo) and remainder (hi) are negated independently.
module muldiv_signfix (
    input  logic        is_div,
    input  logic        neg_main,
    input  logic        neg_rem,
    input  logic [63:0] raw,
    output logic [63:0] fixed
);

    // Select which halves get negated based on the op class.
    always_comb begin
        fixed = raw;
        if (!is_div) begin
            if (neg_main) begin
                fixed = ~raw + 64'd1;
            end
        end else begin
            if (neg_main) begin
                fixed[31:0] = ~raw[31:0] + 32'd1;
            end
            if (neg_rem) begin
                fixed[63:32] = ~raw[63:32] + 32'd1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Multiply is radix-2 shift-add over a 64-bit accumulator; divide is
// restoring division producing one quotient bit per RUN cycle. Both
// work on operand magnitudes; signs are restored on the completion edge.
//
// Handshake: start is a single-cycle request, accepted only when the
// unit is in IDLE or DONE (ignored in RUN, never queued). Operands are
// sampled on the accepting edge. done pulses for one cycle when hi/lo
// hold the new result; busy is high for every RUN cycle.
module hilo_muldiv #(
    parameter int ITER = mips_muldiv_pkg::ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        hilo_read,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    import mips_muldiv_pkg::*;

    // FSM state (observable as hilo_muldiv.state) and control flops.
    state_t      state;
    logic [4:0]  count;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    // Latched operation context.
    muldiv_op_t  op_q;
    logic        sgn_xor_q;
    logic [31:0] a_orig_q;
    logic        b_zero_q;

    // Iteration datapath.
    logic [63:0] mcand_q;
    logic [63:0] prod_q;
    logic [31:0] shreg_q;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Start-side decode.
    muldiv_op_t  op_in;
    logic        in_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        accept;

    assign op_in     = muldiv_op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign a_mag     = cond_abs(op_a, in_signed);
    assign b_mag     = cond_abs(op_b, in_signed);
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));

    // One iteration step, shared by the RUN update and the completion edge.
    logic        is_div;
    logic [63:0] prod_step;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic        last;

    assign is_div    = op_is_div(op_q);
    assign prod_step = prod_q + (shreg_q[0] ? mcand_q : 64'd0);
    assign rem_shift = {rem_q, shreg_q[31]};
    // rem_shift < 2*divisor, so bit 32 of the difference acts as the borrow.
    assign rem_diff  = rem_shift - {1'b0, divisor_q};
    assign q_bit     = ~rem_diff[32];
    assign rem_step  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
    assign quo_step  = {shreg_q[30:0], q_bit};
    assign last      = (state == S_RUN) && (count == 5'(ITER - 1));

    // Completion result: sign fix, then the divide-by-zero override.
    logic [63:0] raw_result;
    logic [63:0] fixed_result;
    logic        neg_main;
    logic        neg_rem;
    logic        dbz_now;
    logic [31:0] final_hi;
    logic [31:0] final_lo;

    assign raw_result = is_div ? {rem_step, quo_step} : prod_step;
    assign neg_main   = op_is_signed(op_q) && sgn_xor_q;
    assign neg_rem    = (op_q == OP_DIV) && a_orig_q[31];
    assign dbz_now    = is_div && b_zero_q;

    muldiv_signfix u_signfix (
        .is_div  (is_div),
        .neg_main(neg_main),
        .neg_rem (neg_rem),
        .raw     (raw_result),
        .fixed   (fixed_result)
    );

    assign final_hi = dbz_now ? a_orig_q : fixed_result[63:32];
    assign final_lo = dbz_now ? 32'hFFFF_FFFF : fixed_result[31:0];

    // Control FSM: IDLE -> RUN for ITER cycles -> DONE for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        count  <= 5'd0;
                    end
                end
                S_RUN: begin
                    count <= count + 5'd1;
                    if (last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        dbz_q  <= dbz_now;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        count  <= 5'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                end
            endcase
        end
    end

    // Load operand magnitudes on accept, then iterate one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_MULT;
            sgn_xor_q <= 1'b0;
            a_orig_q  <= 32'd0;
            b_zero_q  <= 1'b0;
            mcand_q   <= 64'd0;
            prod_q    <= 64'd0;
            shreg_q   <= 32'd0;
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
        end else if (accept) begin
            op_q      <= op_in;
            sgn_xor_q <= op_a[31] ^ op_b[31];
            a_orig_q  <= op_a;
            b_zero_q  <= (op_b == 32'd0);
            mcand_q   <= {32'd0, a_mag};
            prod_q    <= 64'd0;
            // Multiply shifts the multiplier out LSB-first; divide shifts the
            // dividend out MSB-first while quotient bits fill in from below.
            shreg_q   <= op_is_div(op_in) ? a_mag : b_mag;
            divisor_q <= b_mag;
            rem_q     <= 32'd0;
        end else if (state == S_RUN) begin
            if (is_div) begin
                rem_q   <= rem_step;
                shreg_q <= quo_step;
            end else begin
                prod_q  <= prod_step;
                mcand_q <= mcand_q << 1;
                shreg_q <= shreg_q >> 1;
            end
        end
    end

    // HI/LO: completion result, with MTHI/MTLO taking priority per register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (last) begin
                hi_q <= final_hi;
                lo_q <= final_lo;
            end
            if (hi_we) begin
                hi_q <= wdata;
            end
            if (lo_we) begin
                lo_q <= wdata;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign stall       = hilo_read && (state == S_RUN);
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
